circle_anim_ctrl: RTL and testbench

- Sequencer for the rotating-segment animation on the 6-digit 7-segment board.
- Consumes the overflow tick from the free-running counter and two push-buttons (run/pause, direction).
- Steps a single lit segment around the outer perimeter of the display row.
- Drives the current display index and segment index to the seg7 driver.

---
 rtl/circle_anim_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_circle_anim_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/circle_anim_ctrl.sv
// Rotating-segment sequencer for a row of 7-segment digits: debounces the run and
// direction buttons, steps one lit segment around the row perimeter on counter ticks.
module circle_anim_ctrl #(
    parameter int NUM_OF_DISPLAYS = 6,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SPEED_W         = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               tick_i,
    input  logic                               btn_run_i,
    input  logic                               btn_dir_i,
    input  logic [SPEED_W-1:0]                 speed_i,
    output logic [$clog2(NUM_OF_DISPLAYS)-1:0] curr_display_o,
    output logic [2:0]                         seg_idx_o,
    output logic                               directie_o,
    output logic                               active_o,
    output logic                               lap_o
);

    localparam int N      = NUM_OF_DISPLAYS;
    localparam int P      = 2 * N + 4;
    localparam int POS_W  = $clog2(P);
    localparam int DISP_W = $clog2(N);
    localparam int DBC_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int BTN_RUN = 0;
    localparam int BTN_DIR = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    // Perimeter walk: top row left-to-right, right edge down, bottom row right-to-left, left edge up.
    function automatic logic [DISP_W+2:0] map_pos(input logic [POS_W-1:0] p);
        int pi;
        int d;
        int s;
        pi = int'(p);
        if (pi < N) begin
            d = pi;
            s = 0;
        end else if (pi == N) begin
            d = N - 1;
            s = 1;
        end else if (pi == N + 1) begin
            d = N - 1;
            s = 2;
        end else if (pi <= 2 * N + 1) begin
            d = 2 * N + 1 - pi;
            s = 3;
        end else if (pi == 2 * N + 2) begin
            d = 0;
            s = 4;
        end else begin
            d = 0;
            s = 5;
        end
        return {DISP_W'(d), 3'(s)};
    endfunction

    logic [1:0]            btn_raw;
    logic [1:0]            sync1_q;
    logic [1:0]            sync2_q;
    logic [1:0]            deb_q;
    logic [1:0]            deb_d;
    logic [1:0]            deb_prev_q;
    logic [1:0]            press_q;
    logic [1:0][DBC_W-1:0] cnt_q;
    logic [1:0][DBC_W-1:0] cnt_d;

    state_e                state_q;
    state_e                state_d;
    logic [POS_W-1:0]      pos_q;
    logic [POS_W-1:0]      pos_d;
    logic [SPEED_W-1:0]    div_q;
    logic [SPEED_W-1:0]    div_d;
    logic                  dir_q;
    logic                  dir_d;
    logic                  lap_q;
    logic                  lap_d;
    logic [DISP_W-1:0]     disp_q;
    logic [DISP_W-1:0]     disp_d;
    logic [2:0]            seg_q;
    logic [2:0]            seg_d;

    logic                  run_press;
    logic                  dir_press;
    logic                  enter_run;
    logic                  step_en;
    logic                  dir_toggle;

    assign btn_raw   = {btn_dir_i, btn_run_i};
    assign run_press = press_q[BTN_RUN];
    assign dir_press = press_q[BTN_DIR];

    // A level is accepted only after DEBOUNCE_CYCLES consecutive samples differing from the accepted one.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DBC_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + DBC_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            press_q    <= '0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            press_q    <= deb_q & ~deb_prev_q;
            cnt_q      <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (run_press) state_d = RUN;
            RUN:     if (run_press) state_d = PAUSE;
            PAUSE:   if (run_press) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // A run press in the same cycle as a tick takes priority: the tick is dropped.
    always_comb begin
        active_o   = (state_q == RUN) || (state_q == PAUSE);
        enter_run  = (state_q == IDLE) && run_press;
        step_en    = (state_q == RUN) && tick_i && !run_press;
        dir_toggle = dir_press && (state_q != IDLE);
    end

    always_comb begin
        pos_d = pos_q;
        div_d = div_q;
        lap_d = 1'b0;
        dir_d = dir_toggle ? ~dir_q : dir_q;
        if (enter_run) begin
            pos_d = '0;
            div_d = '0;
        end else if (step_en) begin
            // >= rather than == so that lowering speed_i below div still steps.
            if (div_q >= speed_i) begin
                div_d = '0;
                if (dir_q) begin
                    if (pos_q == POS_W'(P - 1)) begin
                        pos_d = '0;
                        lap_d = 1'b1;
                    end else begin
                        pos_d = pos_q + POS_W'(1);
                    end
                end else begin
                    if (pos_q == '0) begin
                        pos_d = POS_W'(P - 1);
                        lap_d = 1'b1;
                    end else begin
                        pos_d = pos_q - POS_W'(1);
                    end
                end
            end else begin
                div_d = div_q + SPEED_W'(1);
            end
        end
    end

    always_comb begin
        disp_d = '0;
        seg_d  = '0;
        if (state_q != IDLE) begin
            {disp_d, seg_d} = map_pos(pos_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pos_q  <= '0;
            div_q  <= '0;
            dir_q  <= 1'b1;
            lap_q  <= 1'b0;
            disp_q <= '0;
            seg_q  <= '0;
        end else begin
            pos_q  <= pos_d;
            div_q  <= div_d;
            dir_q  <= dir_d;
            lap_q  <= lap_d;
            disp_q <= disp_d;
            seg_q  <= seg_d;
        end
    end

    assign curr_display_o = disp_q;
    assign seg_idx_o      = seg_q;
    assign directie_o     = dir_q;
    assign lap_o          = lap_q;

endmodule

// File: tb/tb_circle_anim_ctrl.sv
// Directed bench for circle_anim_ctrl: button debounce latency, stepping, direction,
// pause/resume, speed divider and asynchronous reset.
module tb_circle_anim_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       tick_i = 1'b0;
    logic       btn_run_i = 1'b0;
    logic       btn_dir_i = 1'b0;
    logic [1:0] speed_i = 2'd0;
    logic [2:0] curr_display_o;
    logic [2:0] seg_idx_o;
    logic       directie_o;
    logic       active_o;
    logic       lap_o;

    int vectors = 0;
    int errors  = 0;
    int lap_cnt = 0;
    logic lap_seen = 1'b0;

    int exp_d [16] = '{0, 1, 2, 3, 4, 5, 5, 5, 5, 4, 3, 2, 1, 0, 0, 0};
    int exp_s [16] = '{0, 0, 0, 0, 0, 0, 1, 2, 3, 3, 3, 3, 3, 3, 4, 5};

    circle_anim_ctrl #(
        .NUM_OF_DISPLAYS(6),
        .DEBOUNCE_CYCLES(4),
        .SPEED_W(2)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .tick_i(tick_i),
        .btn_run_i(btn_run_i),
        .btn_dir_i(btn_dir_i),
        .speed_i(speed_i),
        .curr_display_o(curr_display_o),
        .seg_idx_o(seg_idx_o),
        .directie_o(directie_o),
        .active_o(active_o),
        .lap_o(lap_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic chk_pos(input string tag, input int d, input int s);
        chk({tag, ".disp"}, 32'(curr_display_o), 32'(d));
        chk({tag, ".seg"}, 32'(seg_idx_o), 32'(s));
    endtask

    // Tick high for one edge; lap is sampled between the step edge and the next one.
    task automatic do_tick();
        @(negedge clk_i);
        tick_i = 1'b1;
        @(negedge clk_i);
        tick_i   = 1'b0;
        lap_seen = lap_o;
        if (lap_o) lap_cnt++;
        @(negedge clk_i);
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    // Button held 10 cycles; its event reaches the FSM on the 8th edge after the raise,
    // where an optional tick is made to coincide.
    task automatic press(input logic run, input logic dir, input logic tick_at_event);
        @(negedge clk_i);
        btn_run_i = run;
        btn_dir_i = dir;
        repeat (7) @(negedge clk_i);
        tick_i = tick_at_event;
        @(negedge clk_i);
        tick_i = 1'b0;
        repeat (2) @(negedge clk_i);
        btn_run_i = 1'b0;
        btn_dir_i = 1'b0;
        repeat (10) @(negedge clk_i);
    endtask

    initial begin
        // Reset values
        #12;
        chk("rst.active", 32'(active_o), 32'd0);
        chk("rst.dir", 32'(directie_o), 32'd1);
        chk("rst.lap", 32'(lap_o), 32'd0);
        chk_pos("rst", 0, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);

        // Direction press in IDLE is ignored
        press(1'b0, 1'b1, 1'b0);
        chk("idle_dir.dir", 32'(directie_o), 32'd1);
        chk("idle_dir.active", 32'(active_o), 32'd0);

        // Bouncing run button, then stable high: one event, 7 edges after the stable raise
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            btn_run_i = ~btn_run_i;
        end
        @(negedge clk_i);
        btn_run_i = 1'b1;
        repeat (7) @(negedge clk_i);
        chk("bounce.before", 32'(active_o), 32'd0);
        @(negedge clk_i);
        chk("bounce.after", 32'(active_o), 32'd1);
        repeat (3) @(negedge clk_i);
        btn_run_i = 1'b0;
        repeat (10) @(negedge clk_i);
        chk_pos("run_entry", 0, 0);

        // One full clockwise lap at speed 0
        speed_i = 2'd0;
        lap_cnt = 0;
        for (int k = 1; k <= 16; k++) begin
            do_tick();
            chk_pos($sformatf("lap.step%0d", k), exp_d[k % 16], exp_s[k % 16]);
        end
        chk("lap.last", 32'(lap_seen), 32'd1);
        chk("lap.count", 32'(lap_cnt), 32'd1);

        // Speed 2: three ticks per step
        speed_i = 2'd2;
        do_ticks(2);
        chk_pos("spd2.t2", 0, 0);
        do_ticks(7);
        chk_pos("spd2.t9", 3, 0);

        // Back to position 0, then a direction press and one tick wraps to 15
        speed_i = 2'd0;
        do_ticks(13);
        chk_pos("to_zero", 0, 0);
        press(1'b0, 1'b1, 1'b0);
        chk("ccw.dir", 32'(directie_o), 32'd0);
        do_tick();
        chk("ccw.lap", 32'(lap_seen), 32'd1);
        chk_pos("ccw.wrap", 0, 5);

        // Pause keeps outputs and divider; resume continues from div=1
        speed_i = 2'd2;
        do_tick();
        chk_pos("pre_pause", 0, 5);
        press(1'b1, 1'b0, 1'b0);
        do_ticks(20);
        chk_pos("pause.frozen", 0, 5);
        chk("pause.active", 32'(active_o), 32'd1);
        press(1'b1, 1'b0, 1'b0);
        do_tick();
        chk_pos("resume.t1", 0, 5);
        do_tick();
        chk_pos("resume.t2", 0, 4);

        // Speed lowered below current divider count
        speed_i = 2'd3;
        do_ticks(2);
        chk_pos("lower.hold", 0, 4);
        speed_i = 2'd1;
        do_tick();
        chk_pos("lower.step", 0, 3);

        // Direction press coinciding with a step: step uses the old (ccw) direction
        speed_i = 2'd0;
        press(1'b0, 1'b1, 1'b1);
        chk("simul.dir", 32'(directie_o), 32'd1);
        chk_pos("simul.step", 1, 3);
        do_tick();
        chk_pos("simul.next", 0, 3);

        // Run press coinciding with a tick: transition only, no step
        press(1'b1, 1'b0, 1'b1);
        chk_pos("runtick.pos", 0, 3);
        do_tick();
        chk_pos("runtick.paused", 0, 3);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        chk("to7.dir", 32'(directie_o), 32'd0);
        do_ticks(6);
        chk_pos("to7.pos", 5, 2);

        // Asynchronous reset mid-run
        @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst.active", 32'(active_o), 32'd0);
        chk("arst.dir", 32'(directie_o), 32'd1);
        chk("arst.lap", 32'(lap_o), 32'd0);
        chk_pos("arst", 0, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        do_ticks(2);
        chk("post_rst.active", 32'(active_o), 32'd0);
        chk_pos("post_rst", 0, 0);

        // Run and dir together from IDLE: enter RUN, direction untouched
        press(1'b1, 1'b1, 1'b0);
        chk("both.active", 32'(active_o), 32'd1);
        chk("both.dir", 32'(directie_o), 32'd1);
        do_tick();
        chk_pos("both.step", 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
